fp_norm_round: RTL and testbench
================================

Name: fp_norm_round

Overview:
- Sequential normalise-and-round stage placed directly downstream of the fp_adder alignment/add datapath in the FP ALU.
- Accepts a raw sign, exponent and unnormalised 28-bit mantissa sum (carry, hidden bit, fraction, G/R/S).
- Normalises one bit per cycle, rounds to nearest-even, and emits a packed IEEE-754 single with status flags.
- Uses valid/ready handshakes on both sides; holds one operation at a time.

Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 23, stored fraction width. The raw mantissa width is FRAC_W+5.
- EXP_MAX, 255, all-ones exponent, used as the overflow/infinity code.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream operand valid.
- in_ready  out  1  stage can accept; high only in IDLE, and low while rst is high.
- in_sign  in  1  result sign from the adder.
- in_exp  in  8  exponent of the larger operand (biased).
- in_man  in  28  raw mantissa: bit 27 carry, bit 26 hidden, bits 25:3 fraction, bit 2 guard, bit 1 round, bit 0 sticky.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  32  packed {sign, exp[7:0], frac[22:0]}.
- out_overflow  out  1  result saturated to infinity.
- out_underflow  out  1  nonzero result flushed to zero.
- out_inexact  out  1  rounding or flush discarded nonzero bits.

Behaviour:
- Reset (sync): state=IDLE; out_valid=0; out_result=0; all flags=0; internal regs cleared. Reset mid-operation abandons the operation; no output is produced.
- Internal exponent is 10-bit signed, so over/underflow is detected without wrap-around.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture sign, exp (zero-extended) and man; go to NORM.
- NORM (one action per cycle, in this priority order):
  - man==0 → exact zero: result 0x00000000 (+0 regardless of sign), no flags; go to DONE.
  - man[27]=1 → man = man>>1 with bit 0 = old bit1|old bit0 (sticky preserved); exp+1; go to ROUND.
  - man[26]=1 → go to ROUND.
  - exp≤1 → flush: result {sign,31'b0}, underflow=1, inexact=1; go to DONE.
  - Otherwise → man<<1, exp−1, stay in NORM.
- ROUND:
  - Rounding bits: L=man[3], G=man[2], R=man[1], S=man[0].
  - Round up if G&(R|S|L); increment adds 1 at bit 3.
  - inexact = G|R|S.
  - If the increment carries into bit 27: renormalise right by 1 and exp+1.
  - Then, if exp≥EXP_MAX → {sign, 8'hFF, 23'b0}, overflow=1, inexact=1.
  - Else if exp==0 → flush as in NORM.
  - Else result = {sign, exp[7:0], man[25:3]}.
  - Go to DONE.
- DONE:
  - out_valid=1; out_result and flags are stable and held while out_ready=0.
  - On out_ready: go to IDLE with out_valid=0 on the next cycle.
  - in_ready stays 0 until IDLE.
  - There is no same-cycle bypass, so accept and complete never overlap.
- Latency, measured in edges from the accept edge to out_valid high:
  - Zero input: 1.
  - Already normalised or carry input: 2.
  - Input needing k left shifts: 2+k, worst case 2+26.
- Flags are registered with out_result and cleared on acceptance of the next operation.
- An input exponent of 255 with a normalised mantissa follows the overflow path.

Test Plan:
- 1.5+1.5: in_exp=0x7F, in_man=0xC000000, sign 0 → out_result=0x40400000 two edges after accept; all flags 0.
- Left-normalise: in_exp=0x7F, in_man=0x0800000 → 3 shifts; out_result=0x3E000000 at accept+5 edges; inexact=0.
- Round-to-nearest-even:
  - in_exp=0x7F, in_man=0x400000C → 0x3F800002, inexact=1.
  - in_man=0x4000004 → 0x3F800000, inexact=1.
- Rounding overflow: in_exp=0xFE, in_man=0x7FFFFFC → 0x7F800000, overflow=1, inexact=1.
- Zero and flush:
  - in_man=0, in_sign=1 → 0x00000000 at accept+1, no flags.
  - in_exp=0x02, in_man=0x0800000, sign 1 → 0x80000000, underflow=1.
- Handshake and reset:
  - Hold out_ready=0 for 4 cycles after out_valid → out_result and flags stable, in_ready=0; release → IDLE next cycle, in_ready=1.
  - Assert rst during NORM → following cycle out_valid=0, in_ready=1, out_result=0.

Source files
------------

// File: rtl/fp_norm_round.sv
// fp_norm_round
// Normalise-and-round stage that sits after the fp_adder align/add datapath.
// It takes a raw sign, biased exponent and unnormalised mantissa sum,
// normalises it one bit per cycle, rounds to nearest-even and returns a
// packed IEEE-754 single together with overflow/underflow/inexact flags.
// Only one operation is held at a time.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   in_valid       upstream operand valid
//   in_ready       high only while idle (and never during reset)
//   in_sign        result sign from the adder
//   in_exp         biased exponent of the larger operand
//   in_man         raw mantissa {carry, hidden, fraction, guard, round, sticky}
//   out_valid      packed result and flags are valid
//   out_ready      downstream accepts the result
//   out_result     {sign, exponent, fraction}
//   out_overflow   result saturated to infinity
//   out_underflow  nonzero result flushed to zero
//   out_inexact    rounding or flush discarded nonzero bits
module fp_norm_round #(
  parameter int EXP_W   = 8,
  parameter int FRAC_W  = 23,
  parameter int EXP_MAX = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXP_W-1:0]      in_exp,
  input  logic [FRAC_W+4:0]     in_man,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] out_result,
  output logic                  out_overflow,
  output logic                  out_underflow,
  output logic                  out_inexact
);

  localparam int MW = FRAC_W + 5;
  localparam int XW = EXP_W + 2;
  // Width of the part that takes the rounding increment: carry, hidden, fraction.
  localparam int RW = MW - 3;

  localparam logic signed [XW-1:0] EXP_ONE   = XW'(1);
  localparam logic signed [XW-1:0] EXP_ZERO  = '0;
  localparam logic signed [XW-1:0] EXP_LIMIT = XW'(EXP_MAX);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t               state;
  logic                 sign_r;
  logic signed [XW-1:0] exp_r;
  logic [MW-1:0]        man_r;

  logic                 round_up;
  logic                 rnd_inexact;
  logic [RW-1:0]        rnd_sum;
  logic [FRAC_W-1:0]    rnd_frac;
  logic signed [XW-1:0] rnd_exp;

  // The stage can take a new operand only when it is idle; reset forces it low
  // so nothing is accepted on the same edge that clears the stage.
  assign in_ready = (state == IDLE) && !rst;

  // Round-to-nearest-even on the normalised mantissa. The increment is only
  // added above the G/R/S bits, so a carry out of the hidden bit shows up in
  // the top bit of the sum and costs one right shift plus an exponent bump.
  // After that carry the fraction is all zeros, so no sticky bookkeeping is
  // needed for the renormalising shift.
  always_comb begin
    round_up    = man_r[2] & (man_r[1] | man_r[0] | man_r[3]);
    rnd_inexact = |man_r[2:0];
    rnd_sum     = man_r[MW-1:3] + RW'(round_up);
    if (rnd_sum[RW-1]) begin
      rnd_frac = rnd_sum[RW-2:1];
      rnd_exp  = exp_r + EXP_ONE;
    end else begin
      rnd_frac = rnd_sum[RW-3:0];
      rnd_exp  = exp_r;
    end
  end

  // Main sequencer. IDLE captures an operand and clears the previous flags,
  // NORM performs one normalisation action per cycle (zero detect, right shift
  // on carry, stop on hidden bit, flush when the exponent runs out, otherwise
  // shift left), ROUND packs the result and checks the exponent range, and
  // DONE holds the result until downstream takes it. The exponent is carried
  // two bits wider and signed so that increments past the all-ones code and
  // decrements towards zero never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sign_r        <= 1'b0;
      exp_r         <= '0;
      man_r         <= '0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r        <= in_sign;
            exp_r         <= {2'b00, in_exp};
            man_r         <= in_man;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
            state         <= NORM;
          end
        end
        NORM: begin
          if (man_r == '0) begin
            out_result <= '0;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (man_r[MW-1]) begin
            man_r <= {1'b0, man_r[MW-1:2], man_r[1] | man_r[0]};
            exp_r <= exp_r + EXP_ONE;
            state <= ROUND;
          end else if (man_r[MW-2]) begin
            state <= ROUND;
          end else if (exp_r <= EXP_ONE) begin
            out_result    <= {sign_r, {(EXP_W + FRAC_W){1'b0}}};
            out_underflow <= 1'b1;
            out_inexact   <= 1'b1;
            out_valid     <= 1'b1;
            state         <= DONE;
          end else begin
            man_r <= man_r << 1;
            exp_r <= exp_r - EXP_ONE;
          end
        end
        ROUND: begin
          if (rnd_exp >= EXP_LIMIT) begin
            out_result   <= {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            out_overflow <= 1'b1;
            out_inexact  <= 1'b1;
          end else if (rnd_exp == EXP_ZERO) begin
            out_result    <= {sign_r, {(EXP_W + FRAC_W){1'b0}}};
            out_underflow <= 1'b1;
            out_inexact   <= 1'b1;
          end else begin
            out_result  <= {sign_r, rnd_exp[EXP_W-1:0], rnd_frac};
            out_inexact <= rnd_inexact;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round
// Directed and lightly randomised bench for fp_norm_round. A value-level
// reference model (leading-one search, integer round-to-nearest-even) gives
// the expected result, flags and latency for every operand; the directed
// table also pins the model against hand-computed values. One compare
// process checks the DUT on every cycle that out_valid is high.
module tb_fp_norm_round;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_man;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  fp_norm_round dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_man       (in_man),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_underflow(out_underflow),
    .out_inexact  (out_inexact)
  );

  typedef struct {
    bit        pin;
    bit        s;
    bit [7:0]  e;
    bit [27:0] m;
    int        hold;
    bit [31:0] res;
    bit        ov;
    bit        un;
    bit        ix;
    int        lat;
  } vec_t;

  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  int        acc_cyc = 0;
  bit        exp_valid = 0;
  bit        seen_valid = 0;
  bit [31:0] exp_res = 0;
  bit [2:0]  exp_flags = 0;
  int        exp_lat = 0;
  vec_t      vecs[$];

  // Free-running clock and a cycle counter used to measure latency.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: finds the leading one, works out how far normalisation
  // gets before the exponent runs out, rounds the 24-bit significand to
  // nearest-even with plain integer arithmetic and classifies the range.
  function automatic void model(input bit s, input bit [7:0] e, input bit [27:0] m,
                                output bit [31:0] r, output bit ov, output bit un,
                                output bit ix, output int lat);
    int     ex;
    int     p;
    int     k;
    longint mm;
    longint keep;
    longint rem;
    ex = int'(e);
    mm = longint'(m);
    r = 0; ov = 0; un = 0; ix = 0; lat = 0;
    if (m == 0) begin
      lat = 1;
      return;
    end
    if (m[27]) begin
      mm = (mm >> 1) | (mm & 1);
      ex = ex + 1;
      lat = 2;
    end else begin
      p = 0;
      for (int i = 0; i < 27; i++) if (m[i]) p = i;
      k = 26 - p;
      if (k > 0 && ex - k < 1) begin
        lat = ((ex > 1) ? ex - 1 : 0) + 1;
        r = {s, 31'b0};
        un = 1; ix = 1;
        return;
      end
      mm = mm << k;
      ex = ex - k;
      lat = 2 + k;
    end
    keep = mm >> 3;
    rem  = mm % 8;
    if (rem > 4 || (rem == 4 && (keep % 2) == 1)) keep = keep + 1;
    ix = (rem != 0);
    if (keep >= (longint'(1) << 24)) begin
      keep = keep >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) begin
      r = {s, 8'hFF, 23'b0};
      ov = 1; ix = 1;
    end else if (ex == 0) begin
      r = {s, 31'b0};
      un = 1; ix = 1;
    end else begin
      r = {s, ex[7:0], keep[22:0]};
    end
  endfunction

  // Compare process: on every cycle out_valid is high the DUT must match the
  // model, keep in_ready low, and the first valid cycle must land exactly at
  // the modelled latency. A valid with nothing expected is an error.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (!exp_valid) begin
        checkOutput("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        checkOutput("result", out_result, exp_res);
        checkOutput("flags", {29'b0, out_overflow, out_underflow, out_inexact}, {29'b0, exp_flags});
        checkOutput("in_ready_busy", {31'b0, in_ready}, 32'd0);
        if (!seen_valid) begin
          seen_valid = 1;
          checkOutput("latency", cyc - acc_cyc, exp_lat);
        end
      end
    end
  end

  // Runs one operation: pins the model on directed vectors, offers the
  // operand, arms the compare process at the accept edge, holds out_ready
  // low for v.hold valid cycles, then releases and checks the return to idle.
  task automatic applyStimulus(input vec_t v);
    bit [31:0] mr;
    bit        mo, mu, mx;
    int        ml;
    int        n;
    model(v.s, v.e, v.m, mr, mo, mu, mx, ml);
    if (v.pin) begin
      checkOutput("model_result", mr, v.res);
      checkOutput("model_flags", {29'b0, mo, mu, mx}, {29'b0, v.ov, v.un, v.ix});
      checkOutput("model_latency", ml, v.lat);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = v.s;
    in_exp   = v.e;
    in_man   = v.m;
    n = 0;
    while (in_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc    = cyc;
    exp_res    = mr;
    exp_flags  = {mo, mu, mx};
    exp_lat    = ml;
    seen_valid = 0;
    exp_valid  = 1;
    in_valid   = 1'b0;
    n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) begin
      checkOutput("done_timeout", {31'b0, out_valid}, 32'd1);
      exp_valid = 0;
      return;
    end
    repeat (v.hold) begin
      @(negedge clk);
      checkOutput("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_valid = 0;
    @(negedge clk);
    checkOutput("release_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("release_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    vec_t rv;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_man    = '0;
    out_ready = 1'b0;

    // pin  s  exp    man           hold  result        ov un ix lat
    vecs.push_back('{1, 0, 8'h7F, 28'hC000000, 0, 32'h40400000, 0, 0, 0, 2});
    vecs.push_back('{1, 0, 8'h7F, 28'h0800000, 0, 32'h3E000000, 0, 0, 0, 5});
    vecs.push_back('{1, 0, 8'h7F, 28'h400000C, 0, 32'h3F800002, 0, 0, 1, 2});
    vecs.push_back('{1, 0, 8'h7F, 28'h4000004, 0, 32'h3F800000, 0, 0, 1, 2});
    vecs.push_back('{1, 0, 8'h7F, 28'h4000006, 0, 32'h3F800001, 0, 0, 1, 2});
    vecs.push_back('{1, 0, 8'hFE, 28'h7FFFFFC, 0, 32'h7F800000, 1, 0, 1, 2});
    vecs.push_back('{1, 1, 8'h55, 28'h0000000, 0, 32'h00000000, 0, 0, 0, 1});
    vecs.push_back('{1, 1, 8'h02, 28'h0800000, 0, 32'h80000000, 0, 1, 1, 2});
    vecs.push_back('{1, 1, 8'h80, 28'h4000000, 4, 32'hC0000000, 0, 0, 0, 2});
    vecs.push_back('{1, 0, 8'hFF, 28'h4000000, 0, 32'h7F800000, 1, 0, 1, 2});
    vecs.push_back('{1, 0, 8'h00, 28'h4000000, 0, 32'h00000000, 0, 1, 1, 2});
    vecs.push_back('{1, 0, 8'h7F, 28'hC000003, 0, 32'h40400000, 0, 0, 1, 2});
    vecs.push_back('{1, 0, 8'h7F, 28'h0000001, 2, 32'h32800000, 0, 0, 0, 28});

    // Reset state while rst is held, then in_ready once released.
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_out_result", out_result, 32'd0);
    checkOutput("reset_flags", {29'b0, out_overflow, out_underflow, out_inexact}, 32'd0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", {31'b0, in_ready}, 32'd1);

    $display("[TB] directed vectors");
    foreach (vecs[i]) applyStimulus(vecs[i]);

    $display("[TB] randomised operands");
    for (int i = 0; i < 40; i++) begin
      rv.pin  = 0;
      rv.s    = 1'($urandom_range(0, 1));
      rv.e    = 8'($urandom_range(0, 255));
      rv.m    = 28'($urandom) >> $urandom_range(0, 27);
      rv.hold = $urandom_range(0, 2);
      rv.res  = 0; rv.ov = 0; rv.un = 0; rv.ix = 0; rv.lat = 0;
      applyStimulus(rv);
    end

    // Reset in the middle of a long normalisation abandons the operation.
    $display("[TB] reset during normalisation");
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 8'h7F;
    in_man   = 28'h0000100;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_in_ready_low", {31'b0, in_ready}, 32'd0);
    checkOutput("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midreset_out_result", out_result, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (30) @(negedge clk);
    checkOutput("midreset_no_output", {31'b0, out_valid}, 32'd0);

    // Stage still works normally after the abandoned operation.
    applyStimulus(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
